// File: rtl/seven_seg_pkg.sv
// Shared seven-segment types and the active-low hex glyph table.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_TO_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    return HEX_TO_SEG[nib];
  endfunction

endpackage

// File: rtl/seven_segment_scanner_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seven_segment_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment scanner with blank guard and per-frame snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int  NUM_DIGITS   = 8,
  parameter int  REFRESH_DIV  = 100000,
  parameter int  BLANK_CYCLES = 4,
  localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output seg_t                    seg_o,
  output logic                    dp_o,
  output logic [IDX_W-1:0]        sel_o,
  output logic                    frame_tick_o
);

  localparam int               PRE_W     = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (BLANK_CYCLES < 1) begin : g_chk_blank
    $error("BLANK_CYCLES must be at least 1");
  end
  if (REFRESH_DIV < BLANK_CYCLES + 2) begin : g_chk_div
    $error("REFRESH_DIV must be at least BLANK_CYCLES + 2");
  end

  logic [PRE_W-1:0]        pre_cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] shadow_digits_p0;
  logic [NUM_DIGITS-1:0]   shadow_dp_p0;
  logic [NUM_DIGITS-1:0]   shadow_den_p0;
  logic                    vld_p0;
  logic                    slot_end_p0;
  logic                    wrap_p0;
  logic                    frame_start_p0;
  logic [3:0]              nib_p0;
  seg_t                    seg_dec_p0;
  logic [NUM_DIGITS-1:0]   lz_mask_p0;
  logic [NUM_DIGITS-1:0]   anode_nxt_p0;

  logic [NUM_DIGITS-1:0]   anode_p1;
  seg_t                    seg_p1;
  logic                    dp_p1;
  logic [IDX_W-1:0]        sel_p1;
  logic                    tick_p1;

  // ---- stage p0: prescaler, slot index and frame snapshot ----
  assign vld_p0         = en;
  assign slot_end_p0    = (pre_cnt_p0 == PRE_LAST);
  assign wrap_p0        = vld_p0 && slot_end_p0 && (idx_p0 == IDX_LAST);
  assign frame_start_p0 = (pre_cnt_p0 == '0) && (idx_p0 == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_p0       <= '0;
      idx_p0           <= '0;
      shadow_digits_p0 <= '0;
      shadow_dp_p0     <= '0;
      shadow_den_p0    <= '0;
    end else if (vld_p0) begin
      if (slot_end_p0) begin
        pre_cnt_p0 <= '0;
        idx_p0     <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      end else begin
        pre_cnt_p0 <= pre_cnt_p0 + 1'b1;
      end
      if (frame_start_p0) begin
        shadow_digits_p0 <= digits_i;
        shadow_dp_p0     <= dp_i;
        shadow_den_p0    <= digit_en_i;
      end
    end
  end

  assign nib_p0 = shadow_digits_p0[4*int'(idx_p0) +: 4];

  seven_segment_hex_decoder u_dec (
    .nibble (nib_p0),
    .seg    (seg_dec_p0)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic       zero_above_p0;
  logic [3:0] lz_nib_p0;

  // Walk from the most significant slot down; slot 0 always stays eligible.
  always_comb begin
    lz_mask_p0    = '0;
    zero_above_p0 = 1'b1;
    lz_nib_p0     = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_nib_p0 = shadow_digits_p0[4*k +: 4];
      if (zero_above_p0 && (lz_nib_p0 == 4'h0)) lz_mask_p0[k] = 1'b1;
      if (shadow_den_p0[k] && (lz_nib_p0 != 4'h0)) zero_above_p0 = 1'b0;
    end
  end
`else
  assign lz_mask_p0 = '0;
`endif

  always_comb begin
    anode_nxt_p0 = '1;
    if (vld_p0 && (pre_cnt_p0 >= PRE_BLANK) &&
        shadow_den_p0[idx_p0] && !lz_mask_p0[idx_p0]) begin
      anode_nxt_p0[idx_p0] = 1'b0;
    end
  end

  // ---- stage p1: registered pin drive ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_p1 <= '1;
      seg_p1   <= SEG_BLANK;
      dp_p1    <= 1'b1;
      sel_p1   <= '0;
      tick_p1  <= 1'b0;
    end else begin
      anode_p1 <= anode_nxt_p0;
      seg_p1   <= seg_dec_p0;
      dp_p1    <= ~shadow_dp_p0[idx_p0];
      sel_p1   <= idx_p0;
      tick_p1  <= wrap_p0;
    end
  end

  assign anode_o      = anode_p1;
  assign seg_o        = seg_p1;
  assign dp_o         = dp_p1;
  assign sel_o        = sel_p1;
  assign frame_tick_o = tick_p1;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seven_segment_scanner;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  digit_en_i;
  logic [3:0]  anode_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [1:0]  sel_o;
  logic        frame_tick_o;

  seven_segment_scanner #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .digits_i     (digits_i),
    .dp_i         (dp_i),
    .digit_en_i   (digit_en_i),
    .anode_o      (anode_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .sel_o        (sel_o),
    .frame_tick_o (frame_tick_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference state: enabled cycles elapsed in the current frame, plus the frame snapshot.
  int          pos;
  logic [15:0] s_dig;
  logic [3:0]  s_dp;
  logic [3:0]  s_den;

  function automatic bit lz_blank(input int k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 0) return 1'b0;
    if (s_dig[4*k +: 4] != 4'h0) return 1'b0;
    for (int j = k + 1; j < N; j++)
      if (s_den[j] && (s_dig[4*j +: 4] != 4'h0)) return 1'b0;
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [15:0] d,
                            input logic [3:0] p, input logic [3:0] n);
    exp_t x;
    int   slot;
    int   phase;
    if (!r) begin
      pos   = 0;
      s_dig = '0;
      s_dp  = '0;
      s_den = '0;
      x     = '{anode: 4'hF, seg: 7'h7F, dp: 1'b1, sel: 2'd0, tick: 1'b0};
    end else begin
      slot    = pos / DIV;
      phase   = pos % DIV;
      x.sel   = 2'(slot);
      x.seg   = GLYPH[s_dig[4*slot +: 4]];
      x.dp    = ~s_dp[slot];
      x.anode = 4'hF;
      if (e && (phase >= BLANK) && s_den[slot] && !lz_blank(slot)) x.anode[slot] = 1'b0;
      x.tick  = e && (pos == FRAME - 1);
      if (e) begin
        if (pos == 0) begin
          s_dig = d;
          s_dp  = p;
          s_den = n;
        end
        pos = (pos + 1) % FRAME;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step(rst_n, en, digits_i, dp_i, digit_en_i);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      if ({anode_o, seg_o, dp_o, sel_o, frame_tick_o} !== x) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got anode=%h seg=%h dp=%b sel=%0d tick=%b, want anode=%h seg=%h dp=%b sel=%0d tick=%b",
                 $time, anode_o, seg_o, dp_o, sel_o, frame_tick_o,
                 x.anode, x.seg, x.dp, x.sel, x.tick);
      end
      vectors++;
      if (!$onehot0(~anode_o)) begin
        miscompares++;
        $display("FAIL anode_onehot t=%0t: got anode=%b, want at most one low bit", $time, anode_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; digits_i = '0; dp_i = '0; digit_en_i = '0;
    pos = 0; s_dig = '0; s_dp = '0; s_den = '0;
    repeat (3) step();

    rst_n = 1'b1; en = 1'b1;
    digits_i = 16'h4321; dp_i = 4'b0010; digit_en_i = 4'hF;
    repeat (70) step();

    for (int i = 0; i < FRAME && (pos / DIV) != 2; i++) step();
    digits_i = 16'h8888;
    repeat (70) step();

    digits_i = 16'h4321; digit_en_i = 4'b1011;
    repeat (40) step();
    en = 1'b0; repeat (5) step();
    en = 1'b1; repeat (20) step();

    for (int i = 0; i < FRAME && (pos / DIV) != 3; i++) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; repeat (40) step();

    digits_i = 16'h0070; dp_i = 4'b0000; digit_en_i = 4'hF;
    repeat (70) step();

    for (int i = 0; i < FRAME && pos != FRAME - 1; i++) step();
    en = 1'b0; repeat (2) step();
    en = 1'b1; repeat (40) step();

    for (int i = 0; i < 2000; i++) begin
      rst_n      = ($urandom_range(0, 399) != 0);
      en         = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        digits_i   = 16'($urandom);
        dp_i       = 4'($urandom);
        digit_en_i = 4'($urandom);
      end
      step();
    end

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
